// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buffer #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v;
    logic              skid_v;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    logic in_xfer;
    logic out_xfer;
    logic main_free;
    logic load_skid;
    logic load_in;
    logic to_skid;
    logic stalled;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // in_ready comes straight from a flop, so it never depends on out_ready.
    assign in_ready  = !skid_v;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_v && out_ready;
    assign main_free = !main_v || out_xfer;
    assign stalled   = main_v && !out_ready;

    assign load_skid = !flush && main_free && skid_v;
    assign load_in   = !flush && main_free && !skid_v && in_xfer;
    assign to_skid   = !flush && !main_free && in_xfer;

    assign out_valid = main_v;
    assign out_pc    = main_pc;
    assign out_inst  = main_v ? main_inst : NOP_INST;
    assign count     = {1'b0, main_v} + {1'b0, skid_v};

    // Control state and the visible PC; the PC is kept across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_pc   <= '0;
            stall_cnt <= '0;
        end else begin
            if (stalled) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush) begin
                main_v <= 1'b0;
                skid_v <= 1'b0;
            end else if (main_free) begin
                main_v <= skid_v || in_xfer;
                skid_v <= 1'b0;
            end else if (in_xfer) begin
                skid_v <= 1'b1;
            end
            if (load_skid) begin
                main_pc <= skid_pc;
            end else if (load_in) begin
                main_pc <= in_pc;
            end
        end
    end

    // Payload registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            main_inst <= skid_inst;
        end else if (load_in) begin
            main_inst <= in_inst;
        end
        if (to_skid) begin
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: a default instance plus a CNT_W=3
// instance sharing the same inputs for the saturation check.
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  count;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_inst;
    logic [1:0]  s_count;
    logic [2:0]  s_stall_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t q[$];
    int     total = 0;
    int     bad   = 0;
    int     seq   = 0;
    int     exp_stall = 0;
    int     exp_sat   = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .count(count), .stall_cnt(stall_cnt)
    );

    pipe_stage_buffer #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_inst(s_out_inst),
        .count(s_count), .stall_cnt(s_stall_cnt)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        exp_stall = 0;
        exp_sat   = 0;
        seq       = 0;
    endtask

    // One clock of stimulus; the offered entry is derived from seq and is
    // held by the upstream until accepted.
    task automatic step(input bit iv, input bit ordy, input bit fl);
        bit     it;
        bit     stalled;
        entry_t e;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_pc     = 32'(seq * 4);
        in_inst   = 32'(32'hA0 + seq);
        #1;
        total++;
        if (in_ready !== (q.size() < 2)) begin
            bad++;
            $display("FAIL in_ready_pre: got %b want %b", in_ready, (q.size() < 2));
        end
        total++;
        if (out_valid !== (q.size() > 0)) begin
            bad++;
            $display("FAIL out_valid_pre: got %b want %b", out_valid, (q.size() > 0));
        end
        stalled = (q.size() > 0) && !ordy;
        it      = iv && (q.size() < 2);
        if (q.size() > 0 && ordy) begin
            e = q.pop_front();
            total++;
            if (out_pc !== e.pc || out_inst !== e.inst) begin
                bad++;
                $display("FAIL data: got pc=%h inst=%h want pc=%h inst=%h",
                         out_pc, out_inst, e.pc, e.inst);
            end
        end
        if (fl) begin
            q.delete();
        end else if (it) begin
            e.pc   = in_pc;
            e.inst = in_inst;
            q.push_back(e);
        end
        if (it) seq++;
        @(posedge clk);
        #1;
        if (stalled) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_sat < 7) exp_sat++;
        end
        total++;
        if (count !== 2'(q.size())) begin
            bad++;
            $display("FAIL count: got %0d want %0d", count, q.size());
        end
        total++;
        if (q.size() == 0 && out_inst !== 32'h0) begin
            bad++;
            $display("FAIL bubble_inst: got %h want 00000000", out_inst);
        end
        total++;
        if (stall_cnt !== 16'(exp_stall) || s_stall_cnt !== 3'(exp_sat)) begin
            bad++;
            $display("FAIL stall_cnt: got %0d/%0d want %0d/%0d",
                     stall_cnt, s_stall_cnt, exp_stall, exp_sat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b r=%b c=%0d s=%0d want 0 1 0 0",
                     out_valid, in_ready, count, stall_cnt);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h0 ||
            count !== 2'd0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: got v=%b r=%b pc=%h inst=%h c=%0d s=%0d want 0 1 0 0 0 0",
                     out_valid, in_ready, out_pc, out_inst, count, stall_cnt);
        end
        q.delete();
        exp_stall = 0;
        exp_sat   = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        step(0, 1, 0);
        total++;
        if (seq !== 4 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL streaming: got accepted=%0d stall=%0d want 4 0", seq, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        total++;
        if (count !== 2'd2 || in_ready !== 1'b0 || stall_cnt !== 16'd5) begin
            bad++;
            $display("FAIL backpressure: got c=%0d r=%b s=%0d want 2 0 5", count, in_ready, stall_cnt);
        end
        step(1, 1, 0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL skid_drain_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
    endtask

    task automatic test_flush();
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        total++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || count !== 2'd0) begin
            bad++;
            $display("FAIL flush: got v=%b inst=%h c=%0d want 0 0 0", out_valid, out_inst, count);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        step(0, 1, 0);
        // flush with IT and OT in the same cycle
        step(1, 0, 0);
        step(1, 1, 1);
        total++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_it_ot: got c=%0d v=%b want 0 0", count, out_valid);
        end
        step(1, 1, 0);
        step(0, 1, 0);
    endtask

    task automatic test_saturation();
        do_reset();
        step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        total++;
        if (s_stall_cnt !== 3'd7 || stall_cnt !== 16'd10) begin
            bad++;
            $display("FAIL saturation: got %0d/%0d want 7/10", s_stall_cnt, stall_cnt);
        end
        step(0, 1, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        total++;
        if (count !== 2'd0) begin
            bad++;
            $display("FAIL random_drain: got c=%0d want 0", count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
